// File: rtl/moore_seq_detector.sv
// Serial pattern detector (Moore FSM), overlap-selectable, with saturating match counter.
// Ports: clk/reset_n (async active-low), enable gates sampling of data_in, clear = sync clear;
//        match/state_out decoded from state register, match_count/count_sat from counter register.
module moore_seq_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  localparam int              SW      = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             data_in,
  input  logic             clear,
  output logic             match,
  output logic [SW-1:0]    state_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  // Next-state table indexed by {state, bit}; entry = new matched-prefix length.
  typedef logic [2*(PAT_W+1)-1:0][SW-1:0] tbl_t;

  // Built at elaboration from the KMP failure function of PATTERN.
  // PATTERN[PAT_W-1] is the first bit received, so pattern position i is PATTERN[PAT_W-1-i].
  function automatic tbl_t build_tbl();
    tbl_t t;
    int   fail [PAT_W+1];
    int   k;
    int   nxt;
    t       = '0;
    fail[0] = 0;
    fail[1] = 0;
    k       = 0;
    for (int i = 1; i < PAT_W; i++) begin
      while (k > 0 && PATTERN[PAT_W-1-i] != PATTERN[PAT_W-1-k]) k = fail[k];
      if (PATTERN[PAT_W-1-i] == PATTERN[PAT_W-1-k]) k++;
      fail[i+1] = k;
    end
    // Rows are filled in ascending state order; fail[s] < s, so every
    // fallback row referenced below has already been computed.
    for (int s = 0; s <= PAT_W; s++) begin
      for (int b = 0; b < 2; b++) begin
        if (s == PAT_W) begin
          // Full match: either keep the longest border or start over from S0.
          nxt = OVERLAP ? int'(t[2*fail[PAT_W]+b]) : int'(t[b]);
        end else if (PATTERN[PAT_W-1-s] == b[0]) begin
          nxt = s + 1;
        end else if (s == 0) begin
          nxt = 0;
        end else begin
          nxt = int'(t[2*fail[s]+b]);
        end
        t[2*s+b] = SW'(nxt);
      end
    end
    return t;
  endfunction

  localparam tbl_t NEXT_TBL = build_tbl();

  typedef enum logic [SW-1:0] {
    S0      = '0,
    S_MATCH = SW'(PAT_W)
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           step_state;
  logic [CNT_W-1:0] count_nxt;
  logic             sat_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      state       <= state_nxt;
      match_count <= count_nxt;
      count_sat   <= sat_nxt;
    end
  end

  always_comb begin
    step_state = state_t'(NEXT_TBL[{state, data_in}]);
    state_nxt  = state;
    count_nxt  = match_count;
    sat_nxt    = count_sat;
    if (clear) begin
      state_nxt = S0;
      count_nxt = '0;
      sat_nxt   = 1'b0;
    end else if (int'(state) > PAT_W) begin
      // Unused encoding: recover to S0 regardless of enable.
      state_nxt = S0;
    end else if (enable) begin
      state_nxt = step_state;
      // count_sat is only ever set together with an all-ones count, so it
      // doubles as the saturation guard.
      if (step_state == S_MATCH && !count_sat) begin
        count_nxt = match_count + 1'b1;
        sat_nxt   = &count_nxt;
      end
    end
  end

  assign match     = (state == S_MATCH);
  assign state_out = state;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: four instances (default, non-overlap, 2-bit counter,
// all-ones pattern) share one stimulus stream; a suffix-matching history model predicts
// every output each cycle, and directed sequences pin known literal results.
module tb_moore_seq_detector;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic data_in = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic       m0, m1, m2, m3;
  logic [2:0] s0, s1, s2;
  logic [1:0] s3;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [3:0] c3;
  logic       t0, t1, t2, t3;

  moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in), .clear(clear),
    .match(m0), .state_out(s0), .match_count(c0), .count_sat(t0));
  moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in), .clear(clear),
    .match(m1), .state_out(s1), .match_count(c1), .count_sat(t1));
  moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in), .clear(clear),
    .match(m2), .state_out(s2), .match_count(c2), .count_sat(t2));
  moore_seq_detector #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(4)) u3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in), .clear(clear),
    .match(m3), .state_out(s3), .match_count(c3), .count_sat(t3));

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, the bits seen since the last restart (newest in bit 0).
  // Expected state = longest k such that the newest k bits equal the first k pattern bits.
  int pw   [4] = '{4, 4, 4, 3};
  int pat  [4] = '{11, 11, 11, 7};
  int ovl  [4] = '{1, 0, 1, 1};
  int cmax [4] = '{255, 255, 3, 15};
  int m_hist [4];
  int m_hl   [4];
  int m_st   [4];
  int m_cnt  [4];
  int m_sat  [4];

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int longest(input int i);
    for (int k = pw[i]; k >= 1; k--) begin
      if (k <= m_hl[i]) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (((m_hist[i] >> (k-1-j)) & 1) != ((pat[i] >> (pw[i]-1-j)) & 1)) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_reset_one(input int i);
    m_hist[i] = 0; m_hl[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_reset_one(i);
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      if (clear) begin
        model_reset_one(i);
      end else if (enable) begin
        if (m_st[i] == pw[i] && ovl[i] == 0) begin
          m_hist[i] = 0;
          m_hl[i]   = 0;
        end
        m_hist[i] = ((m_hist[i] << 1) | int'(data_in)) & 16'hffff;
        m_hl[i]   = (m_hl[i] < 16) ? m_hl[i] + 1 : 16;
        m_st[i]   = longest(i);
        if (m_st[i] == pw[i]) begin
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
          if (m_cnt[i] == cmax[i]) m_sat[i] = 1;
        end
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("match0", 32'(m0), int'(m_st[0] == pw[0]));
    check("state0", 32'(s0), m_st[0]);
    check("count0", 32'(c0), m_cnt[0]);
    check("sat0",   32'(t0), m_sat[0]);
    check("match1", 32'(m1), int'(m_st[1] == pw[1]));
    check("state1", 32'(s1), m_st[1]);
    check("count1", 32'(c1), m_cnt[1]);
    check("sat1",   32'(t1), m_sat[1]);
    check("match2", 32'(m2), int'(m_st[2] == pw[2]));
    check("state2", 32'(s2), m_st[2]);
    check("count2", 32'(c2), m_cnt[2]);
    check("sat2",   32'(t2), m_sat[2]);
    check("match3", 32'(m3), int'(m_st[3] == pw[3]));
    check("state3", 32'(s3), m_st[3]);
    check("count3", 32'(c3), m_cnt[3]);
    check("sat3",   32'(t3), m_sat[3]);
  end

  // One clock: drive on the falling edge, advance the model on the rising edge.
  task automatic step(input bit en, input bit d, input bit clr);
    @(negedge clk);
    enable  = en;
    data_in = d;
    clear   = clr;
    @(posedge clk);
    model_step();
  endtask

  task automatic bits4(input bit [3:0] v);
    for (int i = 3; i >= 0; i--) step(1'b1, v[i], 1'b0);
  endtask

  task automatic reset_assert();
    #2;
    reset_n = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int exp_cnt2 [5] = '{1, 2, 3, 3, 3};
  bit [6:0] stream1 = 7'b1011011;

  initial begin
    model_reset();
    #2;
    check("rst_match", 32'(m0), 0);
    check("rst_state", 32'(s0), 0);
    check("rst_count", 32'(c0), 0);
    check("rst_sat",   32'(t0), 0);
    repeat (2) @(posedge clk);
    reset_release();

    // Overlapping vs non-overlapping on 1,0,1,1,0,1,1.
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, stream1[i], 1'b0);
      if (i == 3) begin
        #1;
        check("t1_match_bit4", 32'(m0), 1);
        check("t1_state_bit4", 32'(s0), 4);
        check("t1_nov_match_bit4", 32'(m1), 1);
      end
    end
    #1;
    check("t1_state0", 32'(s0), 4);
    check("t1_match0", 32'(m0), 1);
    check("t1_count0", 32'(c0), 2);
    check("t2_state1", 32'(s1), 1);
    check("t2_match1", 32'(m1), 0);
    check("t2_count1", 32'(c1), 1);

    // Saturation on a 2-bit counter: five separated matches after a clear.
    step(1'b1, 1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      bits4(4'b1011);
      #1;
      check("t3_count2", 32'(c2), exp_cnt2[g]);
      check("t3_sat2",   32'(t2), int'(g >= 2));
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end

    // Pattern split by 3-cycle enable gaps with random data in the gaps.
    for (int i = 3; i >= 0; i--) begin
      bit [3:0] p = 4'b1011;
      step(1'b1, p[i], 1'b0);
      repeat (3) step(1'b0, 1'($urandom_range(1)), 1'b0);
    end
    #1;
    check("t4_match0", 32'(m0), 1);
    check("t4_state0", 32'(s0), 4);
    check("t4_count0", 32'(c0), 6);

    // Asynchronous reset mid-pattern.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #1;
    check("t5_state_pre", 32'(s0), 3);
    reset_assert();
    check("t5_state_rst", 32'(s0), 0);
    check("t5_match_rst", 32'(m0), 0);
    check("t5_count_rst", 32'(c0), 0);
    check("t5_sat2_rst",  32'(t2), 0);
    reset_release();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #1;
    check("t5_match_after", 32'(m0), 0);
    check("t5_count_after", 32'(c0), 0);
    check("t5_state_after", 32'(s0), 1);

    // Clear on the same edge as the completing bit.
    bits4(4'b1011);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check("t6_count_pre", 32'(c0), 1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    #1;
    check("t6_state0", 32'(s0), 0);
    check("t6_match0", 32'(m0), 0);
    check("t6_count0", 32'(c0), 0);
    check("t6_count1", 32'(c1), 0);

    // Random traffic with occasional clears and asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(63) == 0));
      if ($urandom_range(499) == 0) begin
        reset_assert();
        check("rnd_rst_state0", 32'(s0), 0);
        reset_release();
      end
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
